// File: rtl/reg_writeback_pkg.sv
// Shared widths, write-source encoding and hold-register layout for the
// register writeback block.
package reg_writeback_pkg;

  localparam int REG_W        = 5;
  localparam int DATA_W       = 32;
  localparam int NUM_REGS     = 1 << REG_W;
  localparam int LD_DEPTH_DEF = 4;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LOAD,
    SRC_HOLD,
    SRC_ALU
  } wb_src_e;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    data_t    data;
  } hold_t;

  // A source is unavailable while a load or a parked ALU result targets it,
  // unless that value is being written right now and can be bypassed.
  function automatic logic src_hazard(input reg_idx_t            ra,
                                      input logic [NUM_REGS-1:0] busy,
                                      input hold_t               hold,
                                      input logic                we,
                                      input reg_idx_t            wa);
    return (ra != '0) && (busy[ra] || (hold.valid && hold.rd == ra))
           && !(we && wa == ra);
  endfunction

endpackage

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: in-order FIFO of outstanding load destinations with wrapping
// pointers; push/pop are ignored when full/empty respectively.
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = LD_DEPTH_DEF,
  parameter int WIDTH = REG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (PTR_W+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd_ptr];
  assign count  = r_count;

  // NOTE: the payload array is deliberately left out of reset; the count and
  // pointers decide which entries are meaningful, so stale data is harmless.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback arbiter: merges in-order load responses with ALU
// results, tracks outstanding load destinations and reports source hazards.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int LD_DEPTH = LD_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  input  logic [REG_W-1:0]          alu_rd,
  input  logic [DATA_W-1:0]         alu_data,
  output logic                      alu_ready,
  input  logic                      ld_issue,
  input  logic [REG_W-1:0]          ld_issue_rd,
  output logic                      ld_ready,
  input  logic                      ld_resp_valid,
  input  logic [DATA_W-1:0]         ld_resp_data,
  output logic                      we,
  output logic [REG_W-1:0]          wa,
  output logic [DATA_W-1:0]         wd,
  input  logic [REG_W-1:0]          ra1,
  input  logic [REG_W-1:0]          ra2,
  output logic                      hazard1,
  output logic                      hazard2,
  output logic [$clog2(LD_DEPTH):0] ld_count,
  output logic                      err
);

  hold_t               r_hold;
  logic [NUM_REGS-1:0] r_busy;
  logic                r_err;

  hold_t               w_hold_next;
  logic [NUM_REGS-1:0] w_busy_next;
  wb_src_e             w_src;
  reg_idx_t            w_head_rd;
  logic                w_full;
  logic                w_empty;
  logic                w_resp_ok;
  logic                w_issue_ok;
  logic                w_alu_acc;

  wb_fifo #(
    .DEPTH (LD_DEPTH),
    .WIDTH (REG_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_issue_ok),
    .push_data (ld_issue_rd),
    .pop       (w_resp_ok),
    .head      (w_head_rd),
    .count     (ld_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Uses the registered full flag, so a same-cycle retire never frees a slot.
  assign ld_ready   = !w_full && !(ld_issue_rd != '0 && r_busy[ld_issue_rd]);
  assign alu_ready  = !r_hold.valid;
  assign w_issue_ok = ld_issue && ld_ready;
  assign w_alu_acc  = alu_valid && alu_ready;
  assign w_resp_ok  = ld_resp_valid && !w_empty;

  // NOTE: combinational blocks assign every output a default first and use
  // blocking '=' so later branches override it without inferring a latch.
  always_comb begin
    w_src = SRC_NONE;
    wa    = '0;
    wd    = '0;
    if (w_resp_ok) begin
      w_src = SRC_LOAD;
      wa    = w_head_rd;
      wd    = ld_resp_data;
    end else if (r_hold.valid) begin
      w_src = SRC_HOLD;
      wa    = r_hold.rd;
      wd    = r_hold.data;
    end else if (w_alu_acc) begin
      w_src = SRC_ALU;
      wa    = alu_rd;
      wd    = alu_data;
    end
  end

  // x0 is never written; reset also masks a live ALU offer.
  assign we = rst && (w_src != SRC_NONE) && (wa != '0);

  assign hazard1 = src_hazard(ra1, r_busy, r_hold, we, wa);
  assign hazard2 = src_hazard(ra2, r_busy, r_hold, we, wa);
  assign err     = r_err;

  always_comb begin
    w_busy_next = r_busy;
    if (w_resp_ok)                         w_busy_next[w_head_rd]   = 1'b0;
    if (w_issue_ok && ld_issue_rd != '0)   w_busy_next[ld_issue_rd] = 1'b1;

    w_hold_next = r_hold;
    if (w_src == SRC_HOLD) w_hold_next.valid = 1'b0;
    // An accepted ALU result that lost arbitration is parked for later.
    if (w_alu_acc && w_src != SRC_ALU) begin
      w_hold_next.valid = 1'b1;
      w_hold_next.rd    = alu_rd;
      w_hold_next.data  = alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      r_hold <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      r_hold <= w_hold_next;
      if (ld_resp_valid && w_empty) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_reg_writeback;

  localparam int LD_DEPTH = 4;
  localparam int CNT_W    = $clog2(LD_DEPTH) + 1;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } alu_t;

  typedef struct {
    logic             we;
    logic             alu_ready;
    logic             ld_ready;
    logic             hz1;
    logic             hz2;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } stat_t;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             alu_valid, ld_issue, ld_resp_valid;
  logic [4:0]       alu_rd, ld_issue_rd, ra1, ra2;
  logic [31:0]      alu_data, ld_resp_data;
  logic             alu_ready, ld_ready, we, hazard1, hazard2, err;
  logic [4:0]       wa;
  logic [31:0]      wd;
  logic [CNT_W-1:0] ld_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0] ldq[$];
  alu_t       holdq[$];
  bit         m_err;
  stat_t      stat_q[$];
  wr_t        wr_q[$];

  reg_writeback #(.LD_DEPTH(LD_DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .ld_issue      (ld_issue),
    .ld_issue_rd   (ld_issue_rd),
    .ld_ready      (ld_ready),
    .ld_resp_valid (ld_resp_valid),
    .ld_resp_data  (ld_resp_data),
    .we            (we),
    .wa            (wa),
    .wd            (wd),
    .ra1           (ra1),
    .ra2           (ra2),
    .hazard1       (hazard1),
    .hazard2       (hazard2),
    .ld_count      (ld_count),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_ldq(input logic [4:0] r);
    foreach (ldq[i]) if (ldq[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (in_ldq(r)) return 1'b1;
    foreach (holdq[i]) if (holdq[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: predicts this cycle's outputs from current inputs, then
  // advances its queues to the post-edge state.
  task automatic model_eval();
    stat_t       s;
    wr_t         w;
    bit          has, resp_ok, alu_acc, issue_ok, from_hold;
    logic [4:0]  xa;
    logic [31:0] xd;
    if (!rst) begin
      ldq.delete();
      holdq.delete();
      m_err       = 1'b0;
      s.we        = 1'b0;
      s.alu_ready = 1'b1;
      s.ld_ready  = 1'b1;
      s.hz1       = 1'b0;
      s.hz2       = 1'b0;
      s.err       = 1'b0;
      s.cnt       = '0;
      stat_q.push_back(s);
      return;
    end
    s.ld_ready  = (ldq.size() < LD_DEPTH) && !(ld_issue_rd != 5'd0 && in_ldq(ld_issue_rd));
    s.alu_ready = (holdq.size() == 0);
    resp_ok  = ld_resp_valid && (ldq.size() > 0);
    alu_acc  = alu_valid && s.alu_ready;
    issue_ok = ld_issue && s.ld_ready;
    has = 1'b0; from_hold = 1'b0; xa = 5'd0; xd = 32'd0;
    if (resp_ok) begin
      has = 1'b1; xa = ldq[0]; xd = ld_resp_data;
    end else if (holdq.size() > 0) begin
      has = 1'b1; xa = holdq[0].rd; xd = holdq[0].data; from_hold = 1'b1;
    end else if (alu_acc) begin
      has = 1'b1; xa = alu_rd; xd = alu_data;
    end
    s.we  = has && (xa != 5'd0);
    s.hz1 = pending(ra1) && !(s.we && xa == ra1);
    s.hz2 = pending(ra2) && !(s.we && xa == ra2);
    s.err = m_err;
    s.cnt = CNT_W'(ldq.size());
    stat_q.push_back(s);
    if (s.we) begin
      w.wa = xa; w.wd = xd;
      wr_q.push_back(w);
    end
    if (ld_resp_valid && ldq.size() == 0) m_err = 1'b1;
    if (resp_ok)   void'(ldq.pop_front());
    if (issue_ok)  ldq.push_back(ld_issue_rd);
    if (from_hold) void'(holdq.pop_front());
    if (alu_acc && (resp_ok || from_hold)) begin
      alu_t a;
      a.rd = alu_rd; a.data = alu_data;
      holdq.push_back(a);
    end
  endtask

  // Monitor: status every cycle, write data whenever the DUT writes.
  initial begin
    stat_t s;
    wr_t   w;
    forever begin
      @(negedge clk);
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        check("we", we, s.we);
        check("alu_ready", alu_ready, s.alu_ready);
        check("ld_ready", ld_ready, s.ld_ready);
        check("hazard1", hazard1, s.hz1);
        check("hazard2", hazard2, s.hz2);
        check("err", err, s.err);
        check("ld_count", ld_count, s.cnt);
      end
      if (we === 1'b1) begin
        if (wr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got wa=%0d wd=0x%0h expected no write", wa, wd);
        end else begin
          w = wr_q.pop_front();
          check("wa", wa, w.wa);
          check("wd", wd, w.wd);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_issue_rd = '0;
    ld_resp_valid = 1'b0; ld_resp_data = '0;
    ra1 = '0; ra2 = '0;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_issue_rd = '0;
    ld_resp_valid = 1'b0; ld_resp_data = '0;
    ra1 = '0; ra2 = '0;

    // Reset state, with a live ALU offer that must not write.
    next_cycle(); alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33; model_eval();
    probe();
    check("rst_we", we, 1'b0);
    check("rst_alu_ready", alu_ready, 1'b1);
    check("rst_ld_ready", ld_ready, 1'b1);
    check("rst_ld_count", ld_count, 0);
    next_cycle(); rst = 1'b1; model_eval();

    // ALU write with a load in flight.
    next_cycle(); ld_issue = 1'b1; ld_issue_rd = 5'd5; model_eval();
    next_cycle(); alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h11; ra1 = 5'd5; model_eval();
    probe();
    check("alu_we", we, 1'b1);
    check("alu_wa", wa, 7);
    check("alu_wd", wd, 32'h11);
    check("alu_hz1", hazard1, 1'b1);

    // Load response beats the ALU; the ALU value drains next cycle.
    next_cycle();
    ld_resp_valid = 1'b1; ld_resp_data = 32'hDEADBEEF;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h22;
    model_eval();
    probe();
    check("ld_wa", wa, 5);
    check("ld_wd", wd, 32'hDEADBEEF);
    next_cycle(); model_eval();
    probe();
    check("hold_wa", wa, 8);
    check("hold_wd", wd, 32'h22);
    check("hold_alu_ready", alu_ready, 1'b0);

    // Fill the FIFO, then issue and retire in the same cycle.
    for (int i = 1; i <= 4; i++) begin
      next_cycle(); ld_issue = 1'b1; ld_issue_rd = 5'(i); model_eval();
    end
    next_cycle(); ld_issue = 1'b1; ld_issue_rd = 5'd6; model_eval();
    probe();
    check("full_count", ld_count, 4);
    check("full_ld_ready", ld_ready, 1'b0);
    next_cycle();
    ld_issue = 1'b1; ld_issue_rd = 5'd6;
    ld_resp_valid = 1'b1; ld_resp_data = 32'hA1;
    model_eval();
    probe();
    check("full_resp_wa", wa, 1);
    check("full_resp_ld_ready", ld_ready, 1'b0);
    next_cycle(); model_eval();
    probe();
    check("full_after_count", ld_count, 3);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); ld_resp_valid = 1'b1; ld_resp_data = $urandom; model_eval();
    end

    // One load per register; bypass clears the hazard on the response cycle.
    next_cycle(); ld_issue = 1'b1; ld_issue_rd = 5'd9; model_eval();
    next_cycle(); ld_issue = 1'b1; ld_issue_rd = 5'd9; ra2 = 5'd9; model_eval();
    probe();
    check("dup_ld_ready", ld_ready, 1'b0);
    check("dup_hz2", hazard2, 1'b1);
    next_cycle(); ld_resp_valid = 1'b1; ld_resp_data = 32'h99; ra2 = 5'd9; model_eval();
    probe();
    check("bypass_hz2", hazard2, 1'b0);
    check("bypass_wa", wa, 9);

    // Load to x0 retires silently; a stray response sets err.
    next_cycle(); ld_issue = 1'b1; ld_issue_rd = 5'd0; model_eval();
    next_cycle(); ld_resp_valid = 1'b1; ld_resp_data = 32'h37; model_eval();
    probe();
    check("x0_we", we, 1'b0);
    next_cycle(); ld_resp_valid = 1'b1; ld_resp_data = 32'h55; model_eval();
    probe();
    check("stray_we", we, 1'b0);
    check("stray_count", ld_count, 0);
    next_cycle(); model_eval();
    probe();
    check("stray_err", err, 1'b1);

    // Reset mid-operation with loads outstanding and a parked ALU value.
    next_cycle(); rst = 1'b0; model_eval();
    next_cycle(); rst = 1'b1; ld_issue = 1'b1; ld_issue_rd = 5'd10; model_eval();
    next_cycle(); ld_issue = 1'b1; ld_issue_rd = 5'd11; model_eval();
    next_cycle(); ld_issue = 1'b1; ld_issue_rd = 5'd12; model_eval();
    next_cycle();
    ld_resp_valid = 1'b1; ld_resp_data = 32'h10;
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h13;
    model_eval();
    next_cycle();
    rst = 1'b0; alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'h14; ra1 = 5'd11;
    model_eval();
    probe();
    check("mid_rst_count", ld_count, 0);
    check("mid_rst_we", we, 1'b0);
    check("mid_rst_hz1", hazard1, 1'b0);
    check("mid_rst_alu_ready", alu_ready, 1'b1);
    next_cycle(); rst = 1'b1; ld_resp_valid = 1'b1; ld_resp_data = 32'h77; ra1 = 5'd11; model_eval();
    probe();
    check("post_rst_we", we, 1'b0);
    check("post_rst_hz1", hazard1, 1'b0);
    next_cycle(); model_eval();
    probe();
    check("post_rst_err", err, 1'b1);
    next_cycle(); rst = 1'b0; model_eval();

    // Random traffic with rare resets and rare stray responses.
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      rst           = ($urandom_range(0, 299) != 0);
      alu_valid     = 1'($urandom_range(0, 1));
      alu_rd        = 5'($urandom_range(0, 31));
      alu_data      = $urandom;
      ld_issue      = ($urandom_range(0, 2) != 0);
      ld_issue_rd   = 5'($urandom_range(0, 15));
      ld_resp_valid = (ldq.size() > 0) ? ($urandom_range(0, 2) == 0)
                                       : ($urandom_range(0, 149) == 0);
      ld_resp_data  = $urandom;
      ra1           = 5'($urandom_range(0, 15));
      ra2           = 5'($urandom_range(0, 15));
      model_eval();
    end

    next_cycle(); model_eval();
    probe();
    n_cmp++;
    if (stat_q.size() != 0 || wr_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d status and %0d writes pending expected 0 and 0",
               stat_q.size(), wr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
